wb_slot_scheduler: RTL and testbench

Central write-back port reservation scheduler for the single register-file write port shared by the ALU, LSU, MUL and DIV pipes.
- The issue stage presents one candidate instruction per cycle, with its pipe ID, fixed EXE latency and destination register.
- The block grants issue only if the write-back cycle that instruction will occupy is free, and only if a non-pipelined unit it needs is idle.
- On grant it records the reservation and exposes, every cycle, which pipe/rd owns the current write-back slot.
- It replaces the per-pipe latency shift registers in the issue logic with one reservation table.

---
 rtl/wb_slot_scheduler_pkg.sv | 29 ++
 rtl/wb_slot_scheduler_if.sv | 36 +++
 rtl/wb_slot_popcount.sv | 17 +
 rtl/wb_slot_scheduler.sv | 112 +++++++++++
 tb/tb_wb_slot_scheduler.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_slot_scheduler_pkg.sv
// Shared sizes, EXE pipe IDs, nominal pipe latencies and the reservation entry type
// for the write-back slot scheduler.
package wb_slot_scheduler_pkg;

    localparam int NUM_PIPES   = 4;
    localparam int MAX_LATENCY = 16;
    localparam int LAT_WIDTH   = $clog2(MAX_LATENCY + 1);
    localparam int REG_WIDTH   = 5;
    localparam int PIPE_WIDTH  = $clog2(NUM_PIPES);

    typedef enum logic [PIPE_WIDTH-1:0] {
        PIPE_ALU = PIPE_WIDTH'(0),
        PIPE_LSU = PIPE_WIDTH'(1),
        PIPE_MUL = PIPE_WIDTH'(2),
        PIPE_DIV = PIPE_WIDTH'(3)
    } pipe_id_e;

    localparam logic [LAT_WIDTH-1:0] LAT_ALU = LAT_WIDTH'(1);
    localparam logic [LAT_WIDTH-1:0] LAT_LSU = LAT_WIDTH'(2);
    localparam logic [LAT_WIDTH-1:0] LAT_MUL = LAT_WIDTH'(3);
    localparam logic [LAT_WIDTH-1:0] LAT_DIV = LAT_WIDTH'(16);

    typedef struct packed {
        logic                  valid;
        logic [PIPE_WIDTH-1:0] pipe;
        logic [REG_WIDTH-1:0]  rd;
    } wb_slot_t;

endpackage

// File: rtl/wb_slot_scheduler_if.sv
// Issue-stage request, write-back slot status and actual write-back strobe bundle.
// The master side is the issue/WB logic, the slave side is the scheduler.
interface wb_slot_scheduler_if;
    import wb_slot_scheduler_pkg::*;

    logic                  req_valid;
    logic [PIPE_WIDTH-1:0] req_pipe;
    logic [LAT_WIDTH-1:0]  req_latency;
    logic [REG_WIDTH-1:0]  req_rd;
    logic                  req_unpipelined;
    logic                  flush;
    logic                  grant;
    logic                  wb_slot_valid;
    logic [PIPE_WIDTH-1:0] wb_slot_pipe;
    logic [REG_WIDTH-1:0]  wb_slot_rd;
    logic                  unpipelined_busy;
    logic [LAT_WIDTH-1:0]  occupancy;
    logic                  wb_wr_en;
    logic [REG_WIDTH-1:0]  wb_rd;
    logic                  err_mismatch;

    modport master (
        output req_valid, req_pipe, req_latency, req_rd, req_unpipelined, flush,
        output wb_wr_en, wb_rd,
        input  grant, wb_slot_valid, wb_slot_pipe, wb_slot_rd,
        input  unpipelined_busy, occupancy, err_mismatch
    );

    modport slave (
        input  req_valid, req_pipe, req_latency, req_rd, req_unpipelined, flush,
        input  wb_wr_en, wb_rd,
        output grant, wb_slot_valid, wb_slot_pipe, wb_slot_rd,
        output unpipelined_busy, occupancy, err_mismatch
    );

endinterface

// File: rtl/wb_slot_popcount.sv
// Combinational population count over a vector of valid bits.
module wb_slot_popcount #(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]       bits,
    output logic [COUNT_WIDTH-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + COUNT_WIDTH'(bits[i]);
        end
    end

endmodule

// File: rtl/wb_slot_scheduler.sv
// Write-back port reservation table shared by the ALU/LSU/MUL/DIV pipes.
// Optional WB_SLOT_CHECK_EN adds a sticky comparator of the real WB strobe against res[0].
module wb_slot_scheduler
    import wb_slot_scheduler_pkg::*;
(
    input logic                clk,
    input logic                rst,
    wb_slot_scheduler_if.slave bus
);

    wb_slot_t               res_q [MAX_LATENCY];
    wb_slot_t               res_d [MAX_LATENCY];
    logic [MAX_LATENCY-1:0] valid_d;
    logic [LAT_WIDTH-1:0]   occ_d;
    logic [LAT_WIDTH-1:0]   occ_q;
    logic [LAT_WIDTH-1:0]   div_cnt_q;
    logic                   div_issued_q;
    logic                   lat_ok;
    logic                   slot_conflict;
    logic                   unp_busy;
    logic                   grant;

    assign lat_ok   = (bus.req_latency != '0) && (bus.req_latency <= LAT_WIDTH'(MAX_LATENCY));
    assign unp_busy = (div_cnt_q != '0) || div_issued_q;

    // res[L] shifts into res[L-1] this cycle, so it is the entry the new request would land on.
    always_comb begin
        slot_conflict = 1'b0;
        for (int k = 1; k < MAX_LATENCY; k++) begin
            if ((bus.req_latency == LAT_WIDTH'(k)) && res_q[k].valid) begin
                slot_conflict = 1'b1;
            end
        end
    end

    assign grant = bus.req_valid && lat_ok && !slot_conflict
                   && !(bus.req_unpipelined && unp_busy) && !bus.flush && !rst;

    always_comb begin
        for (int k = 0; k < MAX_LATENCY - 1; k++) begin
            res_d[k] = res_q[k+1];
        end
        res_d[MAX_LATENCY-1] = '0;
        for (int k = 0; k < MAX_LATENCY; k++) begin
            if (grant && (bus.req_latency == LAT_WIDTH'(k + 1))) begin
                res_d[k] = '{valid: 1'b1, pipe: bus.req_pipe, rd: bus.req_rd};
            end
        end
        for (int k = 0; k < MAX_LATENCY; k++) begin
            valid_d[k] = res_d[k].valid;
        end
    end

    wb_slot_popcount #(
        .WIDTH       (MAX_LATENCY),
        .COUNT_WIDTH (LAT_WIDTH)
    ) u_popcount (
        .bits  (valid_d),
        .count (occ_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_LATENCY; k++) begin
                res_q[k] <= '0;
            end
            occ_q        <= '0;
            div_cnt_q    <= '0;
            div_issued_q <= 1'b0;
        end else begin
            for (int k = 0; k < MAX_LATENCY; k++) begin
                res_q[k] <= res_d[k];
            end
            occ_q        <= occ_d;
            div_issued_q <= grant && bus.req_unpipelined;
            if (grant && bus.req_unpipelined) begin
                div_cnt_q <= bus.req_latency - LAT_WIDTH'(1);
            end else if (div_cnt_q != '0) begin
                div_cnt_q <= div_cnt_q - LAT_WIDTH'(1);
            end
        end
    end

    assign bus.grant            = grant;
    assign bus.wb_slot_valid    = res_q[0].valid;
    assign bus.wb_slot_pipe     = res_q[0].pipe;
    assign bus.wb_slot_rd       = res_q[0].rd;
    assign bus.unpipelined_busy = unp_busy;
    assign bus.occupancy        = occ_q;

`ifdef WB_SLOT_CHECK_EN
    logic err_q;

    // Spurious strobe, missing strobe or wrong rd against the slot owner latches an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((bus.wb_wr_en != res_q[0].valid)
                     || (bus.wb_wr_en && (bus.wb_rd != res_q[0].rd))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_mismatch = err_q;
`else
    logic unused_wb_check;

    assign unused_wb_check  = ^{bus.wb_wr_en, bus.wb_rd};
    assign bus.err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Scoreboard bench for wb_slot_scheduler: a booking-calendar model keyed by absolute
// cycle predicts grants and WB slot owners; a negedge monitor pops and compares.
module tb_wb_slot_scheduler;
    import wb_slot_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst;

    wb_slot_scheduler_if bus ();

    wb_slot_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    gcyc;
        int                    due;
        logic [PIPE_WIDTH-1:0] pipe;
        logic [REG_WIDTH-1:0]  rd;
    } booking_t;

    booking_t book[$];
    bit       grant_q[$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    int       div_from = 0;
    int       div_until = 0;
    bit       err_set = 1'b0;
    int       err_from = 0;
    bit       state_known = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int find_due(int c);
        foreach (book[i]) if (book[i].due == c) return i;
        return -1;
    endfunction

    function automatic int live_count(int c);
        int n = 0;
        foreach (book[i]) if (book[i].gcyc < c && book[i].due >= c) n++;
        return n;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drives one cycle of stimulus, books the predicted outcome, then advances to the next cycle.
    task automatic applyStimulus(input bit v, input int pipe, input int lat, input int rd,
                                 input bit unp, input bit fl, input bit r, input bit bad_wb);
        int n;
        int idx;
        bit g;
        n   = cyc;
        idx = find_due(n);
        rst                 = r;
        bus.req_valid       = v;
        bus.req_pipe        = PIPE_WIDTH'(pipe);
        bus.req_latency     = LAT_WIDTH'(lat);
        bus.req_rd          = REG_WIDTH'(rd);
        bus.req_unpipelined = unp;
        bus.flush           = fl;
        if (bad_wb) begin
            bus.wb_wr_en = 1'b1;
            bus.wb_rd    = (idx >= 0) ? book[idx].rd + 1'b1 : REG_WIDTH'($urandom);
        end else begin
            bus.wb_wr_en = (idx >= 0);
            bus.wb_rd    = (idx >= 0) ? book[idx].rd : '0;
        end
        g = v && lat >= 1 && lat <= MAX_LATENCY && find_due(n + lat) < 0
            && !(unp && n >= div_from && n < div_until) && !fl && !r;
        grant_q.push_back(g);
        if (g) begin
            book.push_back('{n, n + lat, PIPE_WIDTH'(pipe), REG_WIDTH'(rd)});
            if (unp) begin
                div_from  = n + 1;
                div_until = n + ((lat < 2) ? 2 : lat);
            end
        end
`ifdef WB_SLOT_CHECK_EN
        if (!r && bad_wb && !err_set) begin
            err_set  = 1'b1;
            err_from = n + 1;
        end
`endif
        @(posedge clk);
        #1;
        if (r) begin
            book.delete();
            div_from    = 0;
            div_until   = 0;
            err_set     = 1'b0;
            state_known = 1'b1;
        end
        for (int i = book.size() - 1; i >= 0; i--) begin
            if (book[i].due < cyc) book.delete(i);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    int mon_idx;
    bit mon_grant;

    always @(negedge clk) begin
        if (grant_q.size() > 0) begin
            mon_grant = grant_q.pop_front();
            checkOutput("grant", int'(bus.grant), int'(mon_grant));
            if (state_known) begin
                mon_idx = find_due(cyc);
                checkOutput("wb_slot_valid", int'(bus.wb_slot_valid), int'(mon_idx >= 0));
                if (mon_idx >= 0 && bus.wb_slot_valid) begin
                    checkOutput("wb_slot_pipe", int'(bus.wb_slot_pipe), int'(book[mon_idx].pipe));
                    checkOutput("wb_slot_rd", int'(bus.wb_slot_rd), int'(book[mon_idx].rd));
                end
                checkOutput("occupancy", int'(bus.occupancy), live_count(cyc));
                checkOutput("unpipelined_busy", int'(bus.unpipelined_busy),
                            int'(cyc >= div_from && cyc < div_until));
                checkOutput("err_mismatch", int'(bus.err_mismatch),
                            int'(err_set && cyc >= err_from));
            end
        end
    end

    initial begin
        int pipe;
        int lat;
        int sel;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_pipe = '0; bus.req_latency = '0; bus.req_rd = '0;
        bus.req_unpipelined = 1'b0; bus.flush = 1'b0; bus.wb_wr_en = 1'b0; bus.wb_rd = '0;
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
        idle(2);

        $display("[TB] single ALU beat");
        applyStimulus(1, int'(PIPE_ALU), int'(LAT_ALU), 5, 0, 0, 0, 0);
        idle(3);

        $display("[TB] MUL slot blocks late ALU");
        applyStimulus(1, int'(PIPE_MUL), int'(LAT_MUL), 9, 0, 0, 0, 0);
        idle(1);
        applyStimulus(1, int'(PIPE_ALU), int'(LAT_ALU), 4, 0, 0, 0, 0);
        applyStimulus(1, int'(PIPE_ALU), int'(LAT_ALU), 4, 0, 0, 0, 0);
        idle(3);

        $display("[TB] back-to-back DIV");
        applyStimulus(1, int'(PIPE_DIV), int'(LAT_DIV), 20, 1, 0, 0, 0);
        idle(4);
        applyStimulus(1, int'(PIPE_DIV), int'(LAT_DIV), 21, 1, 0, 0, 0);
        idle(9);
        applyStimulus(1, int'(PIPE_DIV), int'(LAT_DIV), 22, 1, 0, 0, 0);
        applyStimulus(1, int'(PIPE_DIV), int'(LAT_DIV), 23, 1, 0, 0, 0);
        idle(18);

        $display("[TB] flush keeps older reservation");
        applyStimulus(1, int'(PIPE_MUL), int'(LAT_MUL), 11, 0, 0, 0, 0);
        applyStimulus(1, int'(PIPE_LSU), int'(LAT_LSU), 12, 0, 1, 0, 0);
        idle(4);

        $display("[TB] illegal latencies and full table");
        applyStimulus(1, int'(PIPE_ALU), 0, 1, 0, 0, 0, 0);
        applyStimulus(1, int'(PIPE_ALU), MAX_LATENCY + 1, 2, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < MAX_LATENCY; i++) applyStimulus(1, int'(PIPE_LSU), MAX_LATENCY, i, 0, 0, 0, 0);
        applyStimulus(1, int'(PIPE_ALU), MAX_LATENCY, 30, 0, 0, 0, 0);
        applyStimulus(1, int'(PIPE_MUL), 5, 31, 0, 0, 0, 0);
        applyStimulus(1, int'(PIPE_ALU), 1, 29, 0, 0, 0, 0);
        idle(3);

        $display("[TB] reset mid-operation");
        applyStimulus(1, int'(PIPE_MUL), 3, 13, 0, 0, 1, 0);
        idle(2);

`ifdef WB_SLOT_CHECK_EN
        $display("[TB] WB rd mismatch");
        applyStimulus(1, int'(PIPE_LSU), int'(LAT_LSU), 7, 0, 0, 0, 0);
        idle(1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
        idle(4);
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
        idle(2);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            pipe = $urandom_range(0, 3);
            sel  = $urandom_range(0, 19);
            lat  = (sel == 0) ? 0 : (sel == 1) ? MAX_LATENCY + 1 : $urandom_range(1, MAX_LATENCY);
            applyStimulus($urandom_range(0, 9) < 7, pipe, lat, $urandom_range(0, 31),
                          pipe == int'(PIPE_DIV), $urandom_range(0, 15) == 0,
                          $urandom_range(0, 199) == 0, 0);
        end
        idle(MAX_LATENCY + 4);

        checkOutput("scoreboard_drained", grant_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
